// File: rtl/seq_divider24.sv
// Multi-cycle unsigned restoring divider. One quotient bit is resolved per
// clock, MSB first, behind a START/DONE handshake. Divide-by-zero completes
// in a single cycle with an all-ones quotient and the dividend as remainder.
module seq_divider24 #(
  parameter int WIDTH = 24
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIVZERO
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvd;        // dividend; quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs;        // latched divisor
  logic [WIDTH-1:0] prem;       // partial remainder; always < divisor, so WIDTH bits hold it
  logic [CW-1:0]    cnt;        // completed restoring steps
  logic [WIDTH:0]   p_shift;    // partial remainder with the next dividend bit appended
  logic [WIDTH:0]   trial;      // trial subtraction; bit WIDTH is the borrow
  logic [WIDTH-1:0] p_nxt;
  logic             q_bit;
  logic             last_step;

  // One restoring step: subtract at WIDTH+1 bits, keep the shifted value on borrow.
  always_comb begin
    p_shift   = {prem, dvd[WIDTH-1]};
    trial     = p_shift - {1'b0, dvs};
    q_bit     = ~trial[WIDTH];
    p_nxt     = q_bit ? trial[WIDTH-1:0] : p_shift[WIDTH-1:0];
    last_step = (cnt == CW'(WIDTH - 1));
  end

  // Next-state logic: leave IDLE only for a non-zero divisor.
  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: if (START && (B != '0)) state_nxt = RUN;
      RUN:  if (last_step)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  assign BUSY = (state == RUN);

  // Datapath: operand capture, shift-and-subtract, result and DONE pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dvd       <= '0;
      dvs       <= '0;
      prem      <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DONE      <= 1'b0;
      DIVZERO   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (B == '0) begin
              Quotient  <= '1;
              Remainder <= A;
              DIVZERO   <= 1'b1;
              DONE      <= 1'b1;
            end else begin
              dvd  <= A;
              dvs  <= B;
              prem <= '0;
              cnt  <= '0;
            end
          end
        end
        RUN: begin
          prem <= p_nxt;
          dvd  <= {dvd[WIDTH-2:0], q_bit};
          cnt  <= cnt + CW'(1);
          if (last_step) begin
            Quotient  <= {dvd[WIDTH-2:0], q_bit};
            Remainder <= p_nxt;
            DIVZERO   <= 1'b0;
            DONE      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider24.sv
// Self-checking bench for seq_divider24: directed corner cases plus randomized
// operands checked against plain '/' and '%' arithmetic.
module tb_seq_divider24;

  localparam int W = 24;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [W-1:0] A, B;
  logic [W-1:0] Quotient, Remainder;
  logic         BUSY, DONE, DIVZERO;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  seq_divider24 #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .A         (A),
    .B         (B),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .DIVZERO   (DIVZERO)
  );

  // Reference: {divzero, quotient, remainder} from plain arithmetic.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, a / b, a % b};
  endfunction

  // Present a request for one edge, then scramble the operand inputs.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    START = 1'b1; A = a; B = b;
    @(posedge CLK); #1;
    START = 1'b0; A = W'($urandom); B = W'($urandom);
  endtask

  // Sample each following cycle until DONE (bounded); count cycles and BUSY
  // cycles and note whether the outputs moved before DONE.
  task automatic wait_done(output int cycles, output int busy_cycles,
                           output bit seen, output bit held);
    logic [W-1:0] q0, r0;
    q0 = Quotient; r0 = Remainder;
    cycles = 0; busy_cycles = 0; seen = 1'b0; held = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      cycles++;
      if (BUSY) busy_cycles++;
      if (DONE) seen = 1'b1;
      else if (Quotient !== q0 || Remainder !== r0) held = 1'b0;
    end
  endtask

  // One full operation with latency, BUSY, result and pulse-width checks.
  task automatic test_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int cycles, busy_cycles, exp_lat, exp_busy;
    bit seen, held;
    logic [2*W:0] exp_res;
    exp_res  = model(a, b);
    exp_lat  = (b == '0) ? 1 : W + 1;
    exp_busy = (b == '0) ? 0 : W;
    @(negedge CLK);
    launch(a, b);
    wait_done(cycles, busy_cycles, seen, held);
    vectors++;
    if (!seen || cycles !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: seen=%0b cycles=%0d expected %0d", name, seen, cycles, exp_lat);
    end
    vectors++;
    if (busy_cycles !== exp_busy) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, exp_busy);
    end
    vectors++;
    if ({DIVZERO, Quotient, Remainder} !== exp_res) begin
      miscompares++;
      $display("FAIL %s a=%0d b=%0d result: got dz=%0b q=%0d r=%0d expected dz=%0b q=%0d r=%0d",
               name, a, b, DIVZERO, Quotient, Remainder,
               exp_res[2*W], exp_res[2*W-1:W], exp_res[W-1:0]);
    end
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL %s held: results changed before DONE, got held=0 expected 1", name);
    end
    @(negedge CLK);
    vectors++;
    if ({DONE, BUSY} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s pulse: got DONE=%0b BUSY=%0b expected 0 0", name, DONE, BUSY);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if ({Quotient, Remainder, BUSY, DONE, DIVZERO} !== '0) begin
      miscompares++;
      $display("FAIL reset: got q=%h r=%h busy=%0b done=%0b dz=%0b expected all 0",
               Quotient, Remainder, BUSY, DONE, DIVZERO);
    end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    test_one("div_100_7", 24'd100, 24'd7);
  endtask

  task automatic test_extremes();
    test_one("max_by_1",   24'hFFFFFF, 24'd1);
    test_one("max_by_max", 24'hFFFFFF, 24'hFFFFFF);
    test_one("small_by_big", 24'd5,    24'd9);
  endtask

  task automatic test_divzero();
    test_one("divzero", 24'd1234, 24'd0);
  endtask

  task automatic test_start_while_busy();
    int done_count, done_at;
    logic [2*W:0] got;
    done_count = 0; done_at = 0; got = '0;
    @(negedge CLK);
    launch(24'd100, 24'd7);
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (DONE) begin
        done_count++;
        done_at = c;
        got = {DIVZERO, Quotient, Remainder};
      end
      START = (c == 10);
      if (c == 10) begin A = 24'd9; B = 24'd3; end
    end
    vectors++;
    if (done_count !== 1 || done_at !== W + 1) begin
      miscompares++;
      $display("FAIL busy_start dones: got count=%0d at=%0d expected count=1 at=%0d",
               done_count, done_at, W + 1);
    end
    vectors++;
    if (got !== {1'b0, 24'd14, 24'd2}) begin
      miscompares++;
      $display("FAIL busy_start result: got dz=%0b q=%0d r=%0d expected 0 14 2",
               got[2*W], got[2*W-1:W], got[W-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    int cycles, busy_cycles;
    bit seen, held;
    @(negedge CLK);
    launch(24'd100, 24'd7);
    wait_done(cycles, busy_cycles, seen, held);
    vectors++;
    if (!seen || {DIVZERO, Quotient, Remainder} !== {1'b0, 24'd14, 24'd2}) begin
      miscompares++;
      $display("FAIL b2b first: seen=%0b got q=%0d r=%0d expected 14 2", seen, Quotient, Remainder);
    end
    launch(24'd50, 24'd6);
    wait_done(cycles, busy_cycles, seen, held);
    vectors++;
    if (!seen || cycles !== W + 1 || busy_cycles !== W) begin
      miscompares++;
      $display("FAIL b2b latency: seen=%0b cycles=%0d busy=%0d expected %0d %0d",
               seen, cycles, busy_cycles, W + 1, W);
    end
    vectors++;
    if ({DIVZERO, Quotient, Remainder} !== {1'b0, 24'd8, 24'd2}) begin
      miscompares++;
      $display("FAIL b2b second: got dz=%0b q=%0d r=%0d expected 0 8 2", DIVZERO, Quotient, Remainder);
    end
  endtask

  task automatic test_reset_midrun();
    int done_count;
    done_count = 0;
    @(negedge CLK);
    launch(24'd100, 24'd7);
    repeat (11) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({Quotient, Remainder, BUSY, DONE, DIVZERO} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: got q=%h r=%h busy=%0b done=%0b dz=%0b expected all 0",
               Quotient, Remainder, BUSY, DONE, DIVZERO);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (DONE || BUSY) done_count++;
    end
    vectors++;
    if (done_count !== 0) begin
      miscompares++;
      $display("FAIL midrun_reset abandon: got %0d DONE/BUSY cycles expected 0", done_count);
    end
    test_one("after_reset_9_3", 24'd9, 24'd3);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = W'($urandom);
        1:       b = W'($urandom_range(1, 15));
        2:       b = W'($urandom) >> $urandom_range(0, W - 1);
        default: b = (i % 8 == 0) ? '0 : W'($urandom_range(1, 1000));
      endcase
      if (i % 5 == 0) a = a >> $urandom_range(0, W - 1);
      test_one("random", a, b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_divzero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
